// File: rtl/traffic_pkg.sv
// traffic_pkg: light codes, phase and error encodings shared by the
// traffic light monitor and controller, plus pair/transition helpers.
package traffic_pkg;

    typedef enum logic [1:0] {
        LT_GREEN  = 2'd0,
        LT_YELLOW = 2'd1,
        LT_RED    = 2'd2,
        LT_OFF    = 2'd3
    } light_e;

    typedef enum logic [2:0] {
        PH_OFF = 3'd0,
        PH_P1  = 3'd1,
        PH_P2  = 3'd2,
        PH_P3  = 3'd3,
        PH_P4  = 3'd4,
        PH_ERR = 3'd7
    } phase_e;

    typedef enum logic [2:0] {
        EC_NONE     = 3'd0,
        EC_CONFLICT = 3'd1,
        EC_ILLEGAL  = 3'd2,
        EC_SHORT    = 3'd3,
        EC_LONG     = 3'd4
    } err_code_e;

    // Any pair that is not one of the five known phases is a conflict,
    // reported as PH_ERR.
    function automatic phase_e classify(input logic [1:0] a,
                                        input logic [1:0] b);
        phase_e ph;
        ph = PH_ERR;
        unique case ({a, b})
            {LT_OFF,    LT_OFF}:    ph = PH_OFF;
            {LT_GREEN,  LT_RED}:    ph = PH_P1;
            {LT_YELLOW, LT_RED}:    ph = PH_P2;
            {LT_RED,    LT_GREEN}:  ph = PH_P3;
            {LT_RED,    LT_YELLOW}: ph = PH_P4;
            default:                ph = PH_ERR;
        endcase
        return ph;
    endfunction

    function automatic logic is_legal(input phase_e cur,
                                      input phase_e nxt);
        logic ok;
        ok = 1'b0;
        if (nxt == cur || nxt == PH_OFF) begin
            ok = 1'b1;
        end else begin
            unique case (cur)
                PH_OFF:  ok = (nxt == PH_P1);
                PH_P1:   ok = (nxt == PH_P2);
                PH_P2:   ok = (nxt == PH_P3);
                PH_P3:   ok = (nxt == PH_P4);
                PH_P4:   ok = (nxt == PH_P1);
                default: ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

endpackage

// File: rtl/traffic_dwell_chk.sv
// traffic_dwell_chk: per-phase dwell counter with short/long checks.
// Ports: clk, rst_n (async active-low), cur_i (current phase),
//   nxt_i (candidate next phase), short_o (leaving too early),
//   long_o (held too long). EN=0 removes the counter entirely.
module traffic_dwell_chk
    import traffic_pkg::*;
#(
    parameter bit          EN         = 1'b1,
    parameter logic [15:0] GREEN_CYC  = 16'd50000,
    parameter logic [15:0] YELLOW_CYC = 16'd10000,
    parameter logic [15:0] TOL        = 16'd2
) (
    input  logic   clk,
    input  logic   rst_n,
    input  phase_e cur_i,
    input  phase_e nxt_i,
    output logic   short_o,
    output logic   long_o
);

    if (EN) begin : g_dwell
        logic [15:0] dwell_q, dwell_d;
        logic        hold, green, timed, adv;
        logic [16:0] nom, dw_ext;

        // Limits are compared in 17 bits so nominal-TOL cannot
        // underflow and nominal+TOL cannot overflow.
        always_comb begin
            hold    = (nxt_i == cur_i);
            green   = (cur_i == PH_P1) || (cur_i == PH_P3);
            timed   = green || (cur_i == PH_P2) || (cur_i == PH_P4);
            adv     = !hold &&
                      (nxt_i inside {PH_P1, PH_P2, PH_P3, PH_P4});
            nom     = green ? {1'b0, GREEN_CYC} : {1'b0, YELLOW_CYC};
            dw_ext  = {1'b0, dwell_q};
            short_o = timed && adv && ((dw_ext + {1'b0, TOL}) < nom);
            // dwell_q >= limit means this hold pushes it past the limit
            long_o  = timed && hold && (dw_ext >= (nom + {1'b0, TOL}));
            dwell_d = 16'd1;
            if (hold) begin
                dwell_d = (dwell_q == '1) ? dwell_q : dwell_q + 16'd1;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                dwell_q <= '0;
            end else begin
                dwell_q <= dwell_d;
            end
        end
    end else begin : g_none
        logic unused_in;
        assign unused_in = ^{clk, rst_n, cur_i, nxt_i};
        assign short_o   = 1'b0;
        assign long_o    = 1'b0;
    end

endmodule

// File: rtl/traffic_monitor.sv
// traffic_monitor: two-light intersection monitor; decodes phase,
// checks sequence, conflicts and (with TRAFFIC_MONITOR_TIMING_EN) dwell.
// Ports: clk, RST_N (async active-low), l1/l2 light codes, clr_err;
//   phase, err (sticky), err_code (first error), cycles (P4->P1 count).
module traffic_monitor
    import traffic_pkg::*;
#(
    parameter logic [15:0] GREEN_CYC  = 16'd50000,
    parameter logic [15:0] YELLOW_CYC = 16'd10000,
    parameter logic [15:0] TOL        = 16'd2
) (
    input  logic       clk,
    input  logic       RST_N,
    input  logic [1:0] l1,
    input  logic [1:0] l2,
    input  logic       clr_err,
    output logic [2:0] phase,
    output logic       err,
    output logic [2:0] err_code,
    output logic [7:0] cycles
);

`ifdef TRAFFIC_MONITOR_TIMING_EN
    localparam bit TIMING_EN = 1'b1;
`else
    localparam bit TIMING_EN = 1'b0;
`endif

    logic [1:0] l1_q, l1_d, l2_q, l2_d;
    phase_e     phase_q, phase_d, smp_ph, cand;
    logic       err_q, err_d;
    err_code_e  code_q, code_d, code_new;
    logic [7:0] cycles_q, cycles_d;
    logic       conflict, illegal, dw_short, dw_long, viol, wrap;

    // Candidate next phase from the sampled pair, before dwell checks.
    // Once in ERR only an OFF sample releases the state.
    always_comb begin
        l1_d     = l1;
        l2_d     = l2;
        smp_ph   = classify(l1_q, l2_q);
        conflict = (smp_ph == PH_ERR);
        illegal  = 1'b0;
        cand     = phase_q;
        if (phase_q == PH_ERR) begin
            cand = (smp_ph == PH_OFF) ? PH_OFF : PH_ERR;
        end else if (conflict) begin
            cand = PH_ERR;
        end else if (is_legal(phase_q, smp_ph)) begin
            cand = smp_ph;
        end else begin
            cand    = PH_ERR;
            illegal = 1'b1;
        end
    end

    traffic_dwell_chk #(
        .EN         (TIMING_EN),
        .GREEN_CYC  (GREEN_CYC),
        .YELLOW_CYC (YELLOW_CYC),
        .TOL        (TOL)
    ) u_dwell (
        .clk     (clk),
        .rst_n   (RST_N),
        .cur_i   (phase_q),
        .nxt_i   (cand),
        .short_o (dw_short),
        .long_o  (dw_long)
    );

    always_comb begin
        viol     = conflict | illegal | dw_short | dw_long;
        code_new = EC_NONE;
        if (conflict) begin
            code_new = EC_CONFLICT;
        end else if (illegal) begin
            code_new = EC_ILLEGAL;
        end else if (dw_short) begin
            code_new = EC_SHORT;
        end else if (dw_long) begin
            code_new = EC_LONG;
        end
        wrap     = (phase_q == PH_P4) && (cand == PH_P1) && !viol;
        phase_d  = viol ? PH_ERR : cand;
        cycles_d = cycles_q + {7'd0, wrap};
        err_d    = err_q;
        code_d   = code_q;
        // A violation beats a simultaneous clear and is latched as new.
        if (viol) begin
            err_d = 1'b1;
            if (!err_q || clr_err) begin
                code_d = code_new;
            end
        end else if (clr_err) begin
            err_d  = 1'b0;
            code_d = EC_NONE;
        end
    end

    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            l1_q     <= LT_OFF;
            l2_q     <= LT_OFF;
            phase_q  <= PH_OFF;
            err_q    <= 1'b0;
            code_q   <= EC_NONE;
            cycles_q <= '0;
        end else begin
            l1_q     <= l1_d;
            l2_q     <= l2_d;
            phase_q  <= phase_d;
            err_q    <= err_d;
            code_q   <= code_d;
            cycles_q <= cycles_d;
        end
    end

    assign phase    = phase_q;
    assign err      = err_q;
    assign err_code = code_q;
    assign cycles   = cycles_q;

endmodule

// File: tb/tb_traffic_monitor.sv
// tb_traffic_monitor: scoreboard bench for traffic_monitor.
// Builds with or without TRAFFIC_MONITOR_TIMING_EN.
module tb_traffic_monitor;

    localparam logic [1:0] G = 2'd0;
    localparam logic [1:0] Y = 2'd1;
    localparam logic [1:0] R = 2'd2;
    localparam logic [1:0] O = 2'd3;

`ifdef TRAFFIC_MONITOR_TIMING_EN
    localparam logic [2:0] SH_PH = 3'd7;
    localparam logic       SH_E  = 1'b1;
    localparam logic [2:0] SH_C  = 3'd3;
    localparam logic [2:0] LG_PH = 3'd7;
    localparam logic       LG_E  = 1'b1;
    localparam logic [2:0] LG_C  = 3'd4;
`else
    localparam logic [2:0] SH_PH = 3'd2;
    localparam logic       SH_E  = 1'b0;
    localparam logic [2:0] SH_C  = 3'd0;
    localparam logic [2:0] LG_PH = 3'd2;
    localparam logic       LG_E  = 1'b0;
    localparam logic [2:0] LG_C  = 3'd0;
`endif

    typedef struct {
        logic [1:0] a;
        logic [1:0] b;
        logic       clr;
        bit         chk;
        logic [2:0] ph;
        logic       e;
        logic [2:0] code;
        logic [7:0] cy;
        string      nm;
    } row_t;

    typedef struct {
        int         due;
        logic [2:0] ph;
        logic       e;
        logic [2:0] code;
        logic [7:0] cy;
        string      nm;
    } exp_t;

    logic       clk = 1'b0;
    logic       RST_N;
    logic [1:0] l1, l2;
    logic       clr_err;
    logic [2:0] phase;
    logic       err;
    logic [2:0] err_code;
    logic [7:0] cycles;

    int   cyc_n = 0;
    int   checks = 0;
    int   failures = 0;
    row_t rows[$];
    exp_t sb[$];

    traffic_monitor #(
        .GREEN_CYC  (16'd20),
        .YELLOW_CYC (16'd5),
        .TOL        (16'd2)
    ) dut (
        .clk      (clk),
        .RST_N    (RST_N),
        .l1       (l1),
        .l2       (l2),
        .clr_err  (clr_err),
        .phase    (phase),
        .err      (err),
        .err_code (err_code),
        .cycles   (cycles)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    function automatic void add(logic [1:0] a, logic [1:0] b, int n);
        for (int k = 0; k < n; k++) begin
            rows.push_back('{a, b, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 8'd0, ""});
        end
    endfunction

    function automatic void chk(logic [1:0] a, logic [1:0] b, logic clr,
                                logic [2:0] ph, logic e, logic [2:0] code,
                                logic [7:0] cy, string nm);
        rows.push_back('{a, b, clr, 1'b1, ph, e, code, cy, nm});
    endfunction

    task automatic test_reset();
        RST_N = 1'b0;
        l1 = O;
        l2 = O;
        clr_err = 1'b0;
        #1;
        checks++;
        if ({phase, err, err_code, cycles} !== 15'd0) begin
            failures++;
            $display("FAIL reset: got ph=%0d err=%0b code=%0d cyc=%0d want all 0",
                     phase, err, err_code, cycles);
        end
        repeat (3) @(negedge clk);
        RST_N = 1'b1;
    endtask

    task automatic test_full_sequence();
        exp_t e;
        int   n;
        add(O, O, 2);
        chk(O, O, 0, 3'd0, 0, 3'd0, 8'd0, "off");
        add(G, R, 19);
        chk(G, R, 0, 3'd1, 0, 3'd0, 8'd0, "p1");
        add(Y, R, 4);
        chk(Y, R, 0, 3'd2, 0, 3'd0, 8'd0, "p2");
        add(R, G, 19);
        chk(R, G, 0, 3'd3, 0, 3'd0, 8'd0, "p3");
        add(R, Y, 4);
        chk(R, Y, 0, 3'd4, 0, 3'd0, 8'd0, "p4");
        chk(G, R, 0, 3'd1, 0, 3'd0, 8'd1, "wrap1");
        n = rows.size();
        for (int i = 0; i < n + 2; i++) begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].due <= cyc_n) begin
                e = sb.pop_front();
                checks++;
                if ({phase, err, err_code, cycles} !== {e.ph, e.e, e.code, e.cy}) begin
                    failures++;
                    $display("FAIL %s: got ph=%0d err=%0b code=%0d cyc=%0d want ph=%0d err=%0b code=%0d cyc=%0d",
                             e.nm, phase, err, err_code, cycles, e.ph, e.e, e.code, e.cy);
                end
            end
            if (i < n) begin
                l1 = rows[i].a;
                l2 = rows[i].b;
                clr_err = rows[i].clr;
                if (rows[i].chk)
                    sb.push_back('{cyc_n + 2, rows[i].ph, rows[i].e,
                                   rows[i].code, rows[i].cy, rows[i].nm});
            end
        end
        rows.delete();
    endtask

    task automatic test_conflict_illegal();
        exp_t e;
        int   n;
        add(G, R, 3);
        chk(G, R, 0, 3'd1, 0, 3'd0, 8'd1, "p1hold");
        chk(G, G, 0, 3'd7, 1, 3'd1, 8'd1, "conflict");
        chk(O, O, 0, 3'd0, 1, 3'd1, 8'd1, "err_off");
        add(O, O, 1);
        chk(O, O, 1, 3'd0, 0, 3'd0, 8'd1, "clr");
        add(O, O, 1);
        add(G, R, 2);
        chk(R, G, 0, 3'd7, 1, 3'd2, 8'd1, "illegal");
        chk(O, O, 0, 3'd0, 1, 3'd2, 8'd1, "err_off2");
        add(O, O, 1);
        chk(O, O, 1, 3'd0, 0, 3'd0, 8'd1, "clr2");
        add(O, O, 1);
        n = rows.size();
        for (int i = 0; i < n + 2; i++) begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].due <= cyc_n) begin
                e = sb.pop_front();
                checks++;
                if ({phase, err, err_code, cycles} !== {e.ph, e.e, e.code, e.cy}) begin
                    failures++;
                    $display("FAIL %s: got ph=%0d err=%0b code=%0d cyc=%0d want ph=%0d err=%0b code=%0d cyc=%0d",
                             e.nm, phase, err, err_code, cycles, e.ph, e.e, e.code, e.cy);
                end
            end
            if (i < n) begin
                l1 = rows[i].a;
                l2 = rows[i].b;
                clr_err = rows[i].clr;
                if (rows[i].chk)
                    sb.push_back('{cyc_n + 2, rows[i].ph, rows[i].e,
                                   rows[i].code, rows[i].cy, rows[i].nm});
            end
        end
        rows.delete();
    endtask

    task automatic test_dwell();
        exp_t e;
        int   n;
        add(G, R, 14);
        chk(G, R, 0, 3'd1, 0, 3'd0, 8'd1, "p1_15");
        chk(Y, R, 0, SH_PH, SH_E, SH_C, 8'd1, "short");
        add(O, O, 1);
        chk(O, O, 0, 3'd0, SH_E, SH_C, 8'd1, "off3");
        add(O, O, 1);
        chk(O, O, 1, 3'd0, 0, 3'd0, 8'd1, "clr3");
        add(O, O, 1);
        add(G, R, 20);
        add(Y, R, 6);
        chk(Y, R, 0, 3'd2, 0, 3'd0, 8'd1, "p2_7");
        chk(Y, R, 0, LG_PH, LG_E, LG_C, 8'd1, "long");
        add(O, O, 2);
        chk(O, O, 1, 3'd0, 0, 3'd0, 8'd1, "clr4");
        add(O, O, 1);
        n = rows.size();
        for (int i = 0; i < n + 2; i++) begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].due <= cyc_n) begin
                e = sb.pop_front();
                checks++;
                if ({phase, err, err_code, cycles} !== {e.ph, e.e, e.code, e.cy}) begin
                    failures++;
                    $display("FAIL %s: got ph=%0d err=%0b code=%0d cyc=%0d want ph=%0d err=%0b code=%0d cyc=%0d",
                             e.nm, phase, err, err_code, cycles, e.ph, e.e, e.code, e.cy);
                end
            end
            if (i < n) begin
                l1 = rows[i].a;
                l2 = rows[i].b;
                clr_err = rows[i].clr;
                if (rows[i].chk)
                    sb.push_back('{cyc_n + 2, rows[i].ph, rows[i].e,
                                   rows[i].code, rows[i].cy, rows[i].nm});
            end
        end
        rows.delete();
    endtask

    task automatic test_clr_priority_reset();
        exp_t e;
        int   n;
        add(G, R, 3);
        chk(G, G, 0, 3'd7, 1, 3'd1, 8'd1, "conf_a");
        chk(G, G, 1, 3'd7, 1, 3'd1, 8'd1, "conf_clr");
        add(O, O, 1);
        chk(O, O, 1, 3'd0, 0, 3'd0, 8'd1, "clr5");
        add(O, O, 1);
        add(G, R, 20);
        add(Y, R, 5);
        add(R, G, 4);
        chk(R, G, 0, 3'd3, 0, 3'd0, 8'd1, "p3_mid");
        n = rows.size();
        for (int i = 0; i < n + 2; i++) begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].due <= cyc_n) begin
                e = sb.pop_front();
                checks++;
                if ({phase, err, err_code, cycles} !== {e.ph, e.e, e.code, e.cy}) begin
                    failures++;
                    $display("FAIL %s: got ph=%0d err=%0b code=%0d cyc=%0d want ph=%0d err=%0b code=%0d cyc=%0d",
                             e.nm, phase, err, err_code, cycles, e.ph, e.e, e.code, e.cy);
                end
            end
            if (i < n) begin
                l1 = rows[i].a;
                l2 = rows[i].b;
                clr_err = rows[i].clr;
                if (rows[i].chk)
                    sb.push_back('{cyc_n + 2, rows[i].ph, rows[i].e,
                                   rows[i].code, rows[i].cy, rows[i].nm});
            end
        end
        rows.delete();
        #2;
        RST_N = 1'b0;
        #1;
        checks++;
        if ({phase, err, err_code, cycles} !== 15'd0) begin
            failures++;
            $display("FAIL async_reset: got ph=%0d err=%0b code=%0d cyc=%0d want all 0",
                     phase, err, err_code, cycles);
        end
        @(negedge clk);
        l1 = O;
        l2 = O;
        clr_err = 1'b0;
        RST_N = 1'b1;
    endtask

    task automatic test_wrap();
        exp_t e;
        int   n;
        add(O, O, 2);
        for (int s = 0; s < 256; s++) begin
            if (s == 1 || s == 255) begin
                chk(G, R, 0, 3'd1, 0, 3'd0, s[7:0], "seq_n");
                add(G, R, 19);
            end else begin
                add(G, R, 20);
            end
            add(Y, R, 5);
            add(R, G, 20);
            add(R, Y, 5);
        end
        chk(G, R, 0, 3'd1, 0, 3'd0, 8'd0, "wrap256");
        n = rows.size();
        for (int i = 0; i < n + 2; i++) begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].due <= cyc_n) begin
                e = sb.pop_front();
                checks++;
                if ({phase, err, err_code, cycles} !== {e.ph, e.e, e.code, e.cy}) begin
                    failures++;
                    $display("FAIL %s: got ph=%0d err=%0b code=%0d cyc=%0d want ph=%0d err=%0b code=%0d cyc=%0d",
                             e.nm, phase, err, err_code, cycles, e.ph, e.e, e.code, e.cy);
                end
            end
            if (i < n) begin
                l1 = rows[i].a;
                l2 = rows[i].b;
                clr_err = rows[i].clr;
                if (rows[i].chk)
                    sb.push_back('{cyc_n + 2, rows[i].ph, rows[i].e,
                                   rows[i].code, rows[i].cy, rows[i].nm});
            end
        end
        rows.delete();
    endtask

    initial begin
        test_reset();
        test_full_sequence();
        test_conflict_illegal();
        test_dwell();
        test_clr_priority_reset();
        test_wrap();
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/traffic_monitor.md
TRAFFIC_MONITOR -- requirements
Module: traffic_monitor

Interface
REQ-001 SHALL have parameter GREEN_CYC, default 16'd50000, expected green dwell in clk cycles.
REQ-002 SHALL have parameter YELLOW_CYC, default 16'd10000, expected yellow dwell in clk cycles.
REQ-003 SHALL have parameter TOL, default 16'd2, allowed +/- dwell deviation in cycles.
REQ-004 SHALL have port clk  input  1  single system clock, rising edge.
REQ-005 SHALL have port RST_N  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port l1  input  2  light 1 code: 0=green, 1=yellow, 2=red, 3=off.
REQ-007 SHALL have port l2  input  2  light 2 code, same encoding.
REQ-008 SHALL have port clr_err  input  1  synchronous clear of sticky error.
REQ-009 SHALL have port phase  output  3  decoded phase: 0=OFF, 1=P1(G/R), 2=P2(Y/R), 3=P3(R/G), 4=P4(R/Y), 7=ERR.
REQ-010 SHALL have port err  output  1  sticky violation flag.
REQ-011 SHALL have port err_code  output  3  first violation: 0=none, 1=conflict pair, 2=illegal transition, 3=dwell short, 4=dwell long.
REQ-012 SHALL have port cycles  output  8  count of completed P4->P1 sequences, wraps 255->0.

Function
REQ-013 SHALL register l1/l2 once; state, err, err_code, cycles update on the following edge (2-edge latency from input change).
REQ-014 SHALL classify the sampled pair as OFF (3,3), P1 (0,2), P2 (1,2), P3 (2,0), P4 (2,1); any other pair is a conflict (code 1).
REQ-015 SHALL accept transitions OFF->P1, P1->P2, P2->P3, P3->P4, P4->P1, any->OFF, and self-hold; any other change is code 2.
REQ-016 SHALL count dwell cycles in the current phase with a 16-bit saturating counter, reloaded to 1 on entering a phase.
REQ-017 SHALL flag code 3 when leaving P1/P3 with dwell < GREEN_CYC-TOL, or leaving P2/P4 with dwell < YELLOW_CYC-TOL.
REQ-018 SHALL flag code 4 on the cycle dwell exceeds GREEN_CYC+TOL (P1/P3) or YELLOW_CYC+TOL (P2/P4), without waiting for exit.
REQ-019 SHALL not check dwell in OFF; OFF->P1 first green dwell is checked normally.
REQ-020 SHALL, on any violation, set err=1, latch err_code only if err was 0 (first error wins), and enter ERR.
REQ-021 SHALL leave ERR only when OFF is sampled; err stays set regardless of phase.
REQ-022 SHALL clear err and err_code on clr_err=1; a violation in the same cycle takes priority and is latched.
REQ-023 SHALL increment cycles on each legal P4->P1 transition only.

Reset
REQ-024 SHALL on RST_N=0 immediately set phase=0, err=0, err_code=0, cycles=0, dwell=0, sampled pair=(3,3).
REQ-025 SHALL treat a reset mid-phase as a fresh start; first legal entry is OFF->P1.

Configuration
REQ-026 SHALL compile dwell checks (REQ-016..018) only when TRAFFIC_MONITOR_TIMING_EN is defined.
REQ-027 SHALL, without TRAFFIC_MONITOR_TIMING_EN, never raise codes 3/4 and omit the dwell counter; sequence and conflict checks unchanged.

Structure
REQ-028 SHALL place light codes, phase encodings and error codes in shared package traffic_pkg, also used by the controller.
REQ-029 SHALL implement the dwell counter and comparisons as sub-module traffic_dwell_chk.

Verification
REQ-030 SHALL cover: reset, (3,3) then full P1..P4 at GREEN_CYC=20, YELLOW_CYC=5, TOL=2 exact dwells -> err=0, cycles=1 after P4->P1.
REQ-031 SHALL cover: apply (0,0) for one cycle in P1 -> err=1, err_code=1, phase=7 two edges later.
REQ-032 SHALL cover: P1 then directly P3 -> err_code=2; then (3,3) -> phase=0, err still 1; clr_err -> err=0.
REQ-033 SHALL cover (timing enabled): P1 held 15 cycles then P2 -> code 3; P2 held 8 cycles -> code 4 at 8th cycle.
REQ-034 SHALL cover: clr_err asserted in same cycle as conflict -> err=1, err_code=1; RST_N pulse mid-P3 -> all outputs 0 asynchronously.
REQ-035 SHALL cover: 256 legal sequences -> cycles wraps to 0, err=0.
